// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: decode, 32x32 register file, ID/EX register; optional load-use detect under ID_LOADUSE_DETECT_EN
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        if_valid,
    input  logic        flush_id,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_if,
    output logic        flush_if,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs1_val,
    output logic [31:0] id_rs2_val,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src_imm,
    output logic        id_alu_src_pc,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_reg_write,
    output logic        id_branch,
    output logic        id_jump,
    output logic [2:0]  id_funct3,
    output logic        id_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7_b5;

    assign opcode    = if_instr[6:0];
    assign rd        = if_instr[11:7];
    assign funct3    = if_instr[14:12];
    assign rs1       = if_instr[19:15];
    assign rs2       = if_instr[24:20];
    assign funct7_b5 = if_instr[30];

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

    // SUB exists only in the register form; OP-IMM with bit 30 set stays ADD
    function automatic logic [3:0] arith_op(input logic is_reg, input logic [2:0] f3, input logic b5);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg && b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [3:0]  dec_alu_op;
    logic [31:0] dec_imm;
    logic        dec_src_imm;
    logic        dec_src_pc;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_writes_rd;
    logic        dec_branch;
    logic        dec_jump;
    logic        dec_illegal;

    // Opcode decode into ALU/memory/control fields
    always_comb begin
        dec_alu_op    = ALU_ADD;
        dec_imm       = 32'd0;
        dec_src_imm   = 1'b0;
        dec_src_pc    = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_writes_rd = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_alu_op    = arith_op(1'b1, funct3, funct7_b5);
                dec_writes_rd = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_alu_op    = arith_op(1'b0, funct3, funct7_b5);
                dec_imm       = imm_i;
                dec_src_imm   = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_LUI: begin
                dec_alu_op    = ALU_PASSB;
                dec_imm       = imm_u;
                dec_src_imm   = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                dec_imm       = imm_u;
                dec_src_imm   = 1'b1;
                dec_src_pc    = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm       = imm_i;
                dec_src_imm   = 1'b1;
                dec_mem_read  = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_STORE: begin
                dec_imm       = imm_s;
                dec_src_imm   = 1'b1;
                dec_mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                dec_alu_op    = ALU_SUB;
                dec_imm       = imm_b;
                dec_branch    = 1'b1;
            end
            OPC_JAL: begin
                dec_imm       = imm_j;
                dec_src_imm   = 1'b1;
                dec_src_pc    = 1'b1;
                dec_jump      = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_JALR: begin
                dec_imm       = imm_i;
                dec_src_imm   = 1'b1;
                dec_jump      = 1'b1;
                dec_writes_rd = 1'b1;
            end
            default: begin
                dec_illegal   = 1'b1;
            end
        endcase
    end

    logic [31:0] rf [32];

    // Register file write port; reset clears every entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin
                rf[k] <= 32'd0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : ((wb_we && (wb_rd == rs1)) ? wb_data : rf[rs1]);
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : ((wb_we && (wb_rd == rs2)) ? wb_data : rf[rs2]);

    logic load_use;

`ifdef ID_LOADUSE_DETECT_EN
    logic uses_rs1;
    logic uses_rs2;
    assign uses_rs1 = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
                      (opcode == OPC_STORE) || (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign load_use = id_valid && id_mem_read && (id_rd != 5'd0) && if_valid &&
                      ((uses_rs1 && (rs1 == id_rd)) || (uses_rs2 && (rs2 == id_rd)));
`else
    assign load_use = 1'b0;
`endif

    assign stall_if = load_use && !flush_id;
    assign flush_if = flush_id;

    logic squash;
    assign squash = flush_id || load_use || !if_valid;

    // ID/EX register: data fields always load, control fields zero on flush/bubble/invalid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid       <= 1'b0;
            id_pc          <= 32'd0;
            id_rs1_val     <= 32'd0;
            id_rs2_val     <= 32'd0;
            id_imm         <= 32'd0;
            id_rs1         <= 5'd0;
            id_rs2         <= 5'd0;
            id_rd          <= 5'd0;
            id_funct3      <= 3'd0;
            id_alu_op      <= 4'd0;
            id_alu_src_imm <= 1'b0;
            id_alu_src_pc  <= 1'b0;
            id_mem_read    <= 1'b0;
            id_mem_write   <= 1'b0;
            id_reg_write   <= 1'b0;
            id_branch      <= 1'b0;
            id_jump        <= 1'b0;
            id_illegal     <= 1'b0;
        end else begin
            id_pc          <= if_pc;
            id_rs1_val     <= rs1_val;
            id_rs2_val     <= rs2_val;
            id_imm         <= dec_imm;
            id_rs1         <= rs1;
            id_rs2         <= rs2;
            id_rd          <= rd;
            id_funct3      <= funct3;
            id_valid       <= !squash;
            id_alu_op      <= squash ? 4'd0 : dec_alu_op;
            id_alu_src_imm <= !squash && dec_src_imm;
            id_alu_src_pc  <= !squash && dec_src_pc;
            id_mem_read    <= !squash && dec_mem_read;
            id_mem_write   <= !squash && dec_mem_write;
            id_reg_write   <= !squash && dec_writes_rd && (rd != 5'd0);
            id_branch      <= !squash && dec_branch;
            id_jump        <= !squash && dec_jump;
            id_illegal     <= !squash && dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage with a behavioural decode/register-file model
module tb_id_stage;

`ifdef ID_LOADUSE_DETECT_EN
    localparam bit LU = 1'b1;
`else
    localparam bit LU = 1'b0;
`endif

    localparam logic [6:0] M_OP     = 7'b0110011;
    localparam logic [6:0] M_OPIMM  = 7'b0010011;
    localparam logic [6:0] M_LUI    = 7'b0110111;
    localparam logic [6:0] M_AUIPC  = 7'b0010111;
    localparam logic [6:0] M_LOAD   = 7'b0000011;
    localparam logic [6:0] M_STORE  = 7'b0100011;
    localparam logic [6:0] M_BRANCH = 7'b1100011;
    localparam logic [6:0] M_JAL    = 7'b1101111;
    localparam logic [6:0] M_JALR   = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        flush_id;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_if;
    logic        flush_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_imm;
    logic        id_alu_src_pc;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_reg_write;
    logic        id_branch;
    logic        id_jump;
    logic [2:0]  id_funct3;
    logic        id_illegal;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
        .flush_id(flush_id), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_if(stall_if), .flush_if(flush_if), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src_imm(id_alu_src_imm), .id_alu_src_pc(id_alu_src_pc),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_branch(id_branch), .id_jump(id_jump), .id_funct3(id_funct3), .id_illegal(id_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  alu_op;
        logic        src_imm;
        logic        src_pc;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        br;
        logic        jp;
        logic        ill;
    } exp_t;

    exp_t        cur;
    logic [31:0] mrf [32];
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_we && wb_rd == r) return wb_data;
        return mrf[r];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        logic [3:0] tab [8];
        logic [2:0] f3;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        f3 = ins[14:12];
        i_imm = 32'($signed(ins) >>> 20);
        s_imm = 32'(($signed(ins) >>> 25) * 32) + 32'(ins[11:7]);
        b_imm = (ins[31] ? 32'hFFFFF000 : 32'd0) + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
        u_imm = ins & 32'hFFFFF000;
        j_imm = (ins[31] ? 32'hFFF00000 : 32'd0) + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
        e = '0;
        e.valid = 1'b1;
        e.pc = pc;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd = ins[11:7];
        e.f3 = f3;
        case (ins[6:0])
            M_OP: begin
                e.alu_op = tab[f3];
                if (ins[30] && f3 == 3'd0) e.alu_op = 4'd1;
                if (ins[30] && f3 == 3'd5) e.alu_op = 4'd7;
                e.rw = 1'b1;
            end
            M_OPIMM: begin
                e.alu_op = tab[f3];
                if (ins[30] && f3 == 3'd5) e.alu_op = 4'd7;
                e.imm = i_imm; e.src_imm = 1'b1; e.rw = 1'b1;
            end
            M_LUI:    begin e.alu_op = 4'd10; e.imm = u_imm; e.src_imm = 1'b1; e.rw = 1'b1; end
            M_AUIPC:  begin e.imm = u_imm; e.src_imm = 1'b1; e.src_pc = 1'b1; e.rw = 1'b1; end
            M_LOAD:   begin e.imm = i_imm; e.src_imm = 1'b1; e.mr = 1'b1; e.rw = 1'b1; end
            M_STORE:  begin e.imm = s_imm; e.src_imm = 1'b1; e.mw = 1'b1; end
            M_BRANCH: begin e.alu_op = 4'd1; e.imm = b_imm; e.br = 1'b1; end
            M_JAL:    begin e.imm = j_imm; e.src_imm = 1'b1; e.src_pc = 1'b1; e.jp = 1'b1; e.rw = 1'b1; end
            M_JALR:   begin e.imm = i_imm; e.src_imm = 1'b1; e.jp = 1'b1; e.rw = 1'b1; end
            default:  e.ill = 1'b1;
        endcase
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic model_hazard();
        logic [6:0] op;
        logic u1, u2;
        op = if_instr[6:0];
        u1 = (op == M_OP) || (op == M_OPIMM) || (op == M_LOAD) || (op == M_STORE) || (op == M_BRANCH) || (op == M_JALR);
        u2 = (op == M_OP) || (op == M_STORE) || (op == M_BRANCH);
        return LU && cur.valid && cur.mr && (cur.rd != 5'd0) && if_valid &&
               ((u1 && if_instr[19:15] == cur.rd) || (u2 && if_instr[24:20] == cur.rd));
    endfunction

    function automatic logic model_stall();
        return model_hazard() && !flush_id;
    endfunction

    task automatic tick();
        exp_t nx;
        if (!rst_n) begin
            nx = '0;
            for (int k = 0; k < 32; k++) mrf[k] = 32'd0;
        end else begin
            nx = model_decode(if_pc, if_instr);
            nx.rs1v = model_read(if_instr[19:15]);
            nx.rs2v = model_read(if_instr[24:20]);
            if (flush_id || model_hazard() || !if_valid) begin
                nx.valid = 1'b0; nx.alu_op = 4'd0; nx.src_imm = 1'b0; nx.src_pc = 1'b0;
                nx.mr = 1'b0; nx.mw = 1'b0; nx.rw = 1'b0; nx.br = 1'b0; nx.jp = 1'b0; nx.ill = 1'b0;
            end
            if (wb_we && wb_rd != 5'd0) mrf[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
        cur = nx;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic v, input logic fl);
        if_pc = pc; if_instr = ins; if_valid = v; flush_id = fl;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        tests++;
        if ({id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd, id_funct3} !== '0) begin
            fails++; $display("FAIL reset_data got %h want 0", {id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd, id_funct3});
        end
        tests++;
        if ({id_alu_op, id_alu_src_imm, id_alu_src_pc, id_mem_read, id_mem_write, id_reg_write, id_branch, id_jump, id_illegal} !== 12'd0) begin
            fails++; $display("FAIL reset_ctrl got %h want 0", {id_alu_op, id_alu_src_imm, id_alu_src_pc, id_mem_read, id_mem_write, id_reg_write, id_branch, id_jump, id_illegal});
        end
        tests++;
        if (stall_if !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall_if); end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        drive(32'h100, 32'h00500093, 1'b1, 1'b0);
        tick();
        tests++;
        if ({id_valid, id_imm, id_rd, id_alu_op, id_alu_src_imm, id_reg_write} !== {1'b1, 32'd5, 5'd1, 4'd0, 1'b1, 1'b1}) begin
            fails++; $display("FAIL addi got %h want %h", {id_valid, id_imm, id_rd, id_alu_op, id_alu_src_imm, id_reg_write}, {1'b1, 32'd5, 5'd1, 4'd0, 1'b1, 1'b1});
        end
        tests++;
        if (id_pc !== 32'h100) begin fails++; $display("FAIL addi_pc got %h want 100", id_pc); end
    endtask

    task automatic test_writethrough();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        drive(32'h104, 32'h00318233, 1'b1, 1'b0);
        tick();
        tests++;
        if ({id_rs1_val, id_rs2_val} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            fails++; $display("FAIL wt_bypass got %h %h want deadbeef", id_rs1_val, id_rs2_val);
        end
        wb_we = 1'b0;
        drive(32'h108, 32'h00318233, 1'b1, 1'b0);
        tick();
        tests++;
        if (id_rs1_val !== 32'hDEADBEEF) begin fails++; $display("FAIL wt_commit got %h want deadbeef", id_rs1_val); end
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
        drive(32'h10C, 32'h00000233, 1'b1, 1'b0);
        tick();
        tests++;
        if (id_rs1_val !== 32'd0) begin fails++; $display("FAIL x0_bypass got %h want 0", id_rs1_val); end
        wb_we = 1'b0;
        tick();
        tests++;
        if (id_rs2_val !== 32'd0) begin fails++; $display("FAIL x0_commit got %h want 0", id_rs2_val); end
    endtask

    task automatic test_branch();
        drive(32'h110, 32'hFE208CE3, 1'b1, 1'b0);
        tick();
        tests++;
        if ({id_imm, id_branch, id_alu_op, id_reg_write} !== {32'hFFFFFFF8, 1'b1, 4'd1, 1'b0}) begin
            fails++; $display("FAIL beq got %h want %h", {id_imm, id_branch, id_alu_op, id_reg_write}, {32'hFFFFFFF8, 1'b1, 4'd1, 1'b0});
        end
    endtask

    task automatic test_illegal();
        drive(32'h114, 32'hFFFFFFFF, 1'b1, 1'b0);
        tick();
        tests++;
        if ({id_illegal, id_reg_write, id_mem_write, id_mem_read} !== 4'b1000) begin
            fails++; $display("FAIL illegal got %b want 1000", {id_illegal, id_reg_write, id_mem_write, id_mem_read});
        end
    endtask

    task automatic test_loaduse();
        int stalls, bubbles;
        logic issued;
        stalls = 0; bubbles = 0; issued = 1'b0;
        drive(32'h200, 32'h0000A283, 1'b1, 1'b0);
        tick();
        drive(32'h204, 32'h00228333, 1'b1, 1'b0);
        for (int c = 0; c < 3 && !issued; c++) begin
            if (stall_if) stalls++;
            tick();
            if (id_valid && id_rd == 5'd6) issued = 1'b1;
            else if (!id_valid) bubbles++;
        end
        tests++;
        if (stalls != int'(LU)) begin fails++; $display("FAIL lu_stall_cycles got %0d want %0d", stalls, int'(LU)); end
        tests++;
        if (bubbles != int'(LU)) begin fails++; $display("FAIL lu_bubbles got %0d want %0d", bubbles, int'(LU)); end
        tests++;
        if (!issued || id_rs1 !== 5'd5) begin fails++; $display("FAIL lu_issue got issued=%b rs1=%0d want issued=1 rs1=5", issued, id_rs1); end
    endtask

    task automatic test_flush();
        drive(32'h300, 32'h00318233, 1'b1, 1'b1);
        tests++;
        if (flush_if !== 1'b1) begin fails++; $display("FAIL flush_if got %b want 1", flush_if); end
        tick();
        tests++;
        if (id_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", id_valid); end
        drive(32'h304, 32'h0000A283, 1'b1, 1'b0);
        tick();
        drive(32'h308, 32'h00228333, 1'b1, 1'b1);
        tests++;
        if (stall_if !== 1'b0) begin fails++; $display("FAIL flush_hazard_stall got %b want 0", stall_if); end
        tick();
        tests++;
        if (id_valid !== 1'b0) begin fails++; $display("FAIL flush_hazard_valid got %b want 0", id_valid); end
        flush_id = 1'b0;
    endtask

    task automatic test_midstream_reset();
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFEF00D;
        rst_n = 1'b0;
        drive(32'h400, 32'h00500093, 1'b1, 1'b0);
        tick();
        tests++;
        if ({id_valid, id_reg_write, id_imm} !== 34'd0) begin
            fails++; $display("FAIL midrst_id got %h want 0", {id_valid, id_reg_write, id_imm});
        end
        rst_n = 1'b1; wb_we = 1'b0;
        drive(32'h404, 32'h00718233, 1'b1, 1'b0);
        tick();
        tests++;
        if ({id_rs1_val, id_rs2_val} !== 64'd0) begin
            fails++; $display("FAIL midrst_rf got %h %h want 0 0", id_rs1_val, id_rs2_val);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [9];
        logic [31:0] ins;
        logic        es;
        int          sel;
        ops = '{M_OP, M_OPIMM, M_LUI, M_AUIPC, M_LOAD, M_STORE, M_BRANCH, M_JAL, M_JALR};
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            sel = $urandom_range(0, 10);
            if (sel < 9) ins[6:0] = ops[sel];
            if (sel == 4 || sel == 5) ins[6:0] = M_LOAD;
            ins[19:18] = 2'b00; ins[24:23] = 2'b00; ins[11:10] = 2'b00;
            rst_n   = ($urandom_range(0, 79) != 0);
            wb_we   = $urandom_range(0, 1);
            wb_rd   = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            drive($urandom, ins, ($urandom_range(0, 5) != 0), ($urandom_range(0, 9) == 0));
            es = model_stall();
            tests++;
            if (stall_if !== es) begin fails++; $display("FAIL rnd_stall n=%0d got %b want %b", n, stall_if, es); end
            tests++;
            if (flush_if !== flush_id) begin fails++; $display("FAIL rnd_flush_if n=%0d got %b want %b", n, flush_if, flush_id); end
            tick();
            tests++;
            if (id_valid !== cur.valid) begin fails++; $display("FAIL rnd_valid n=%0d got %b want %b", n, id_valid, cur.valid); end
            tests++;
            if ({id_alu_op, id_alu_src_imm, id_alu_src_pc, id_mem_read, id_mem_write, id_reg_write, id_branch, id_jump, id_illegal} !==
                {cur.alu_op, cur.src_imm, cur.src_pc, cur.mr, cur.mw, cur.rw, cur.br, cur.jp, cur.ill}) begin
                fails++;
                $display("FAIL rnd_ctrl n=%0d got %h want %h", n,
                    {id_alu_op, id_alu_src_imm, id_alu_src_pc, id_mem_read, id_mem_write, id_reg_write, id_branch, id_jump, id_illegal},
                    {cur.alu_op, cur.src_imm, cur.src_pc, cur.mr, cur.mw, cur.rw, cur.br, cur.jp, cur.ill});
            end
            if (cur.valid) begin
                tests++;
                if ({id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd, id_funct3} !==
                    {cur.pc, cur.rs1v, cur.rs2v, cur.imm, cur.rs1, cur.rs2, cur.rd, cur.f3}) begin
                    fails++;
                    $display("FAIL rnd_data n=%0d got %h want %h", n,
                        {id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd, id_funct3},
                        {cur.pc, cur.rs1v, cur.rs2v, cur.imm, cur.rs1, cur.rs2, cur.rd, cur.f3});
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        cur = '0;
        test_reset();
        test_addi();
        test_writethrough();
        test_branch();
        test_illegal();
        test_loaduse();
        test_flush();
        test_midstream_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
